// File: rtl/regfile_streamer.sv
// Load/dump streaming engine for a register file: walks a wrapping index range,
// writing words from a valid/ready input or reading words out to a valid/ready output.
module regfile_streamer #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SIZE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmdValid_i,
  output logic             cmdReady_o,
  input  logic             cmdOp_i,
  input  logic [N-1:0]     cmdBase_i,
  input  logic [N:0]       cmdLen_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [WIDTH-1:0] inData_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [WIDTH-1:0] outData_o,
  output logic [N-1:0]     readReq_o,
  input  logic [WIDTH-1:0] readResp_i,
  output logic             writeEn_o,
  output logic [N-1:0]     writeIndex_o,
  output logic [WIDTH-1:0] writeData_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_e;

  localparam logic [N-1:0] LAST  = N'(SIZE - 1);
  localparam logic [N-1:0] ONE_I = N'(1);
  localparam logic [N:0]   ONE_L = (N+1)'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [N:0]       rem_q, rem_d;
  logic [N:0]       iss_q, iss_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ovld_q, ovld_d;

  logic [N-1:0] idx_nxt;
  logic         hold_free;
  logic         out_hs;

  assign idx_nxt   = (idx_q == LAST) ? '0 : idx_q + ONE_I;
  assign hold_free = !ovld_q || outReady_i;
  assign out_hs    = ovld_q && outReady_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      iss_q   <= '0;
      odata_q <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      iss_q   <= iss_d;
      odata_q <= odata_d;
      ovld_q  <= ovld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    iss_d   = iss_q;
    odata_d = odata_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: begin
        if (cmdValid_i) begin
          idx_d = cmdBase_i;
          rem_d = cmdLen_i;
          iss_d = cmdLen_i;
          if (cmdLen_i == '0) state_d = DONE;
          else                state_d = cmdOp_i ? DUMP : LOAD;
        end
      end
      LOAD: begin
        if (inValid_i) begin
          idx_d = idx_nxt;
          rem_d = rem_q - ONE_L;
          if (rem_q == ONE_L) state_d = DONE;
        end
      end
      DUMP: begin
        // remaining counts delivered beats, issued counts reads; the last beat
        // leaves with issued==0 so the holding register drains to empty.
        if (out_hs) begin
          rem_d = rem_q - ONE_L;
          if (rem_q == ONE_L) state_d = DONE;
        end
        if (hold_free) begin
          if (iss_q != '0) begin
            odata_d = readResp_i;
            ovld_d  = 1'b1;
            idx_d   = idx_nxt;
            iss_d   = iss_q - ONE_L;
          end else begin
            ovld_d  = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset is synchronous, so outputs are masked by rst_n to look idle during the reset cycle itself.
  assign cmdReady_o   = !rst_n || (state_q == IDLE);
  assign inReady_o    = rst_n && (state_q == LOAD);
  assign writeEn_o    = rst_n && (state_q == LOAD) && inValid_i;
  assign writeIndex_o = idx_q;
  assign writeData_o  = inData_i;
  assign readReq_o    = idx_q;
  assign outValid_o   = rst_n && ovld_q;
  assign outData_o    = rst_n ? odata_q : '0;
  assign done_o       = rst_n && (state_q == DONE);

endmodule

// File: tb/tb_regfile_streamer.sv
// Bench for regfile_streamer: two instances (size 8 and size 4) run in lockstep on
// shared commands, each against its own register file and reference contents.
module tb_regfile_streamer;

  logic       clk, rst_n;
  logic       cmdValid, cmdOp, inValid, outReady;
  logic [2:0] cmdBaseA, cmdBaseB;
  logic [3:0] cmdLen;
  logic [7:0] inData;

  logic       cmdReadyA, inReadyA, outValidA, writeEnA, doneA;
  logic [7:0] outDataA, readRespA, writeDataA;
  logic [2:0] readReqA, writeIndexA;
  logic       cmdReadyB, inReadyB, outValidB, writeEnB, doneB;
  logic [7:0] outDataB, readRespB, writeDataB;
  logic [2:0] readReqB, writeIndexB;

  logic [7:0] rfA [8];
  logic [7:0] rfB [4];
  logic [7:0] mA  [8];
  logic [7:0] mB  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               op;
    int               ba;
    int               bb;
    int               len;
    int               mode;   // 0: always ready/valid, 1: ready pattern 1,0,0,1,1, 2: random
    bit               tab;    // d/eb hold fixed expectations for a dump
    logic [15:0][7:0] d;      // load data, or expected dump words for A
    logic [15:0][7:0] eb;     // expected dump words for B
  } vec_t;

  regfile_streamer #(.WIDTH(8), .N(3), .SIZE(8)) dutA (
    .clk(clk), .rst_n(rst_n),
    .cmdValid_i(cmdValid), .cmdReady_o(cmdReadyA), .cmdOp_i(cmdOp),
    .cmdBase_i(cmdBaseA), .cmdLen_i(cmdLen),
    .inValid_i(inValid), .inReady_o(inReadyA), .inData_i(inData),
    .outValid_o(outValidA), .outReady_i(outReady), .outData_o(outDataA),
    .readReq_o(readReqA), .readResp_i(readRespA),
    .writeEn_o(writeEnA), .writeIndex_o(writeIndexA), .writeData_o(writeDataA),
    .done_o(doneA)
  );

  regfile_streamer #(.WIDTH(8), .N(3), .SIZE(4)) dutB (
    .clk(clk), .rst_n(rst_n),
    .cmdValid_i(cmdValid), .cmdReady_o(cmdReadyB), .cmdOp_i(cmdOp),
    .cmdBase_i(cmdBaseB), .cmdLen_i(cmdLen),
    .inValid_i(inValid), .inReady_o(inReadyB), .inData_i(inData),
    .outValid_o(outValidB), .outReady_i(outReady), .outData_o(outDataB),
    .readReq_o(readReqB), .readResp_i(readRespB),
    .writeEn_o(writeEnB), .writeIndex_o(writeIndexB), .writeData_o(writeDataB),
    .done_o(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign readRespA = rfA[readReqA];
  assign readRespB = rfB[readReqB[1:0]];

  always @(posedge clk) begin
    if (writeEnA) rfA[writeIndexA] <= writeDataA;
    if (writeEnB) rfB[writeIndexB[1:0]] <= writeDataB;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit op, int ba, int bb, int len, int mode);
    vec_t v;
    v.op = op; v.ba = ba; v.bb = bb; v.len = len; v.mode = mode;
    v.tab = 1'b1; v.d = '0; v.eb = '0;
    return v;
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, " cmdReadyA"}, cmdReadyA, 1);
    chk({tag, " cmdReadyB"}, cmdReadyB, 1);
    chk({tag, " inReadyA"},  inReadyA,  0);
    chk({tag, " outValidA"}, outValidA, 0);
    chk({tag, " outValidB"}, outValidB, 0);
    chk({tag, " outDataA"},  outDataA,  0);
    chk({tag, " writeEnA"},  writeEnA,  0);
    chk({tag, " writeEnB"},  writeEnB,  0);
    chk({tag, " doneA"},     doneA,     0);
    chk({tag, " doneB"},     doneB,     0);
  endtask

  task automatic run_cmd(input vec_t v);
    int  k, cyc, iss;
    bit  exp_v, pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = v.op; cmdLen = 4'(v.len);
    cmdBaseA = 3'(v.ba); cmdBaseB = 3'(v.bb);
    #1;
    chk("accept cmdReadyA", cmdReadyA, 1);
    chk("accept cmdReadyB", cmdReadyB, 1);
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    k = 0; cyc = 0; iss = 0; exp_v = 1'b0;
    while (k < v.len && cyc < 300) begin
      if (v.op == 1'b0) begin
        inValid  = (v.mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        inData   = v.d[k];
        outReady = 1'($urandom);
        #1;
        chk("load inReadyA", inReadyA, 1);
        chk("load inReadyB", inReadyB, 1);
        chk("load writeEnA", writeEnA, inValid);
        chk("load writeEnB", writeEnB, inValid);
        chk("load outValidA", outValidA, 0);
        chk("load doneA", doneA, 0);
        if (inValid) begin
          chk("load writeIndexA", writeIndexA, (v.ba + k) % 8);
          chk("load writeIndexB", writeIndexB, (v.bb + k) % 4);
          chk("load writeDataA", writeDataA, v.d[k]);
          chk("load writeDataB", writeDataB, v.d[k]);
        end
        @(posedge clk);
        if (inValid) begin
          mA[(v.ba + k) % 8] = v.d[k];
          mB[(v.bb + k) % 4] = v.d[k];
          k++;
        end
      end else begin
        outReady = (v.mode == 0) ? 1'b1 :
                   (v.mode == 1) ? ((cyc < 5) ? pat[cyc] : 1'b1) : 1'($urandom);
        inValid  = 1'($urandom);
        inData   = 8'($urandom);
        #1;
        chk("dump writeEnA", writeEnA, 0);
        chk("dump writeEnB", writeEnB, 0);
        chk("dump inReadyA", inReadyA, 0);
        chk("dump doneA", doneA, 0);
        chk("dump outValidA", outValidA, exp_v);
        chk("dump outValidB", outValidB, exp_v);
        if (exp_v) begin
          chk("dump outDataA", outDataA, mA[(v.ba + k) % 8]);
          chk("dump outDataB", outDataB, mB[(v.bb + k) % 4]);
          if (v.tab) begin
            chk("vec outDataA", outDataA, v.d[k]);
            chk("vec outDataB", outDataB, v.eb[k]);
          end
        end
        @(posedge clk);
        // One-entry output buffer: a beat leaves on handshake, a new read fills any free slot.
        if (exp_v && outReady) k++;
        if (!exp_v || outReady) begin
          exp_v = (iss < v.len);
          if (exp_v) iss++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("beats transferred", k, v.len);
    inValid = 1'b0; outReady = 1'b0;
    #1;
    chk("done pulse A", doneA, 1);
    chk("done pulse B", doneB, 1);
    chk("done outValidA", outValidA, 0);
    chk("done writeEnA", writeEnA, 0);
    chk("done writeEnB", writeEnB, 0);
    @(negedge clk);
    #1;
    chk("post-done cmdReadyA", cmdReadyA, 1);
    chk("post-done cmdReadyB", cmdReadyB, 1);
    chk("post-done doneA", doneA, 0);
  endtask

  vec_t tbl [9];
  vec_t v;

  initial begin
    for (int i = 0; i < 8; i++) begin rfA[i] = 8'h00; mA[i] = 8'h00; end
    for (int i = 0; i < 4; i++) begin rfB[i] = 8'h00; mB[i] = 8'h00; end

    tbl[0] = mk(0, 0, 0, 4, 0); tbl[0].d[3:0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tbl[1] = mk(1, 0, 0, 4, 0); tbl[1].d[3:0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
                                tbl[1].eb[3:0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tbl[2] = mk(0, 6, 2, 4, 0); tbl[2].d[3:0] = {8'h13, 8'h12, 8'h11, 8'h10};
    tbl[3] = mk(1, 6, 2, 4, 0); tbl[3].d[3:0] = {8'h13, 8'h12, 8'h11, 8'h10};
                                tbl[3].eb[3:0] = {8'h13, 8'h12, 8'h11, 8'h10};
    tbl[4] = mk(1, 0, 0, 3, 1); tbl[4].d[2:0] = {8'hA2, 8'h13, 8'h12};
                                tbl[4].eb[2:0] = {8'h10, 8'h13, 8'h12};
    tbl[5] = mk(0, 0, 0, 0, 0);
    tbl[6] = mk(1, 0, 0, 0, 0);
    tbl[7] = mk(0, 0, 0, 5, 0); tbl[7].d[4:0] = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    tbl[8] = mk(1, 0, 0, 8, 0);
    tbl[8].d[7:0]  = {8'h11, 8'h10, 8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    tbl[8].eb[7:0] = {8'h04, 8'h03, 8'h02, 8'h05, 8'h04, 8'h03, 8'h02, 8'h05};

    rst_n = 1'b0; cmdValid = 1'b0; cmdOp = 1'b0; cmdBaseA = '0; cmdBaseB = '0;
    cmdLen = '0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    #1 idle_outputs("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 idle_outputs("after reset");
    chk("after reset readReqA", readReqA, 0);

    for (int i = 0; i < 9; i++) run_cmd(tbl[i]);

    // Reset two beats into a six-word dump.
    @(negedge clk);
    cmdValid = 1'b1; cmdOp = 1'b1; cmdLen = 4'd6; cmdBaseA = 3'd2; cmdBaseB = 3'd1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0; outReady = 1'b1;
    #1 chk("rst-seq first cycle outValidA", outValidA, 0);
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("rst-seq beat outValidA", outValidA, 1);
      chk("rst-seq beat outDataA", outDataA, mA[2 + j]);
      chk("rst-seq beat outDataB", outDataB, mB[1 + j]);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1 idle_outputs("mid-dump reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; outReady = 1'b1;
    #1 idle_outputs("post abort");
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort no doneA", doneA, 0);
      chk("abort no outValidA", outValidA, 0);
    end
    v = mk(1, 5, 3, 3, 0); v.tab = 1'b0;
    run_cmd(v);

    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom), int'($urandom_range(7)), int'($urandom_range(3)),
             int'($urandom_range(15)), int'($urandom_range(2)));
      v.tab = 1'b0;
      for (int j = 0; j < 16; j++) v.d[j] = 8'($urandom);
      run_cmd(v);
    end

    for (int i = 0; i < 8; i++) chk("final rfA", rfA[i], mA[i]);
    for (int i = 0; i < 4; i++) chk("final rfB", rfB[i], mB[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
